// File: rtl/i2c_write3_master.sv
// Bit-level I2C master: one 3-byte write (slave addr, sub addr, data) per GO request.
// Bus timing comes from a quarter-bit tick derived from iCLK; SCL is push-pull, SDA open-drain.
//
// state | meaning
// IDLE  | bus idle, waiting for iGO
// START | 4-tick START condition
// BIT   | 8 data bit slots of the current byte
// ACK   | 9th slot, SDA released and sampled
// STOP  | 4-tick STOP condition
// DONE  | oEND high until iGO drops
module i2c_write3_master #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000,
  parameter int DIV      = CLK_FREQ / (4 * I2C_FREQ)
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oEND,
  output logic        oACK,
  output logic        oBUSY,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tick_cnt_q;
  logic        tick;
  logic [1:0]  ph_q, ph_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic        samp_q, samp_d;
  logic        ack_q, ack_d;
  logic        scl_q, scl_d;
  logic        oe_q, oe_d;
  logic        sda_meta_q, sda_sync_q;

  assign I2C_SDAT = oe_q ? 1'b0 : 1'bz;
  assign I2C_SCLK = scl_q;
  assign oEND     = (state_q == DONE);
  assign oBUSY    = (state_q != IDLE) && (state_q != DONE);
  assign oACK     = ack_q;

  assign tick = (state_q != IDLE) && (tick_cnt_q == 16'(DIV - 1));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      tick_cnt_q <= 16'd0;
    end else if (state_q == IDLE || tick) begin
      tick_cnt_q <= 16'd0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      sda_meta_q <= I2C_SDAT;
      sda_sync_q <= sda_meta_q;
    end
  end

  // Bus levels as {scl, sda_oe} for a given state/phase and current data bit.
  function automatic logic [1:0] bus_levels(state_t s, logic [1:0] ph, logic data_bit);
    logic slot_scl;
    slot_scl = (ph == 2'd1) || (ph == 2'd2);
    case (s)
      START:   bus_levels = {(ph == 2'd0), 1'b1};
      BIT:     bus_levels = {slot_scl, ~data_bit};
      ACK:     bus_levels = {slot_scl, 1'b0};
      STOP:    bus_levels = {(ph != 2'd0), (ph < 2'd2)};
      default: bus_levels = 2'b10;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    ack_d      = ack_q;
    case (state_q)
      IDLE: begin
        if (iGO && !oEND) begin
          shift_d = iDATA;
          ack_d   = 1'b0;
          ph_d    = 2'd0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd3) begin
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 2'd0;
            state_d    = BIT;
          end
        end
      end
      BIT: begin
        if (tick) begin
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd3) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ACK;
          end
        end
      end
      ACK: begin
        if (tick) begin
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd2) begin
            samp_d = sda_sync_q;
            if (sda_sync_q) ack_d = 1'b1;
          end
          if (ph_q == 2'd3) begin
            // A NACK skips any remaining bytes.
            if (!samp_q && byte_cnt_q != 2'd2) begin
              byte_cnt_d = byte_cnt_q + 2'd1;
              bit_cnt_d  = 3'd0;
              state_d    = BIT;
            end else begin
              state_d = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          ph_d = ph_q + 2'd1;
          if (ph_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        if (!iGO) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    {scl_d, oe_d} = bus_levels(state_d, ph_d, shift_d[23]);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= IDLE;
      ph_q       <= 2'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      samp_q     <= 1'b0;
      ack_q      <= 1'b0;
      scl_q      <= 1'b1;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      ack_q      <= ack_d;
      scl_q      <= scl_d;
      oe_q       <= oe_d;
    end
  end

endmodule
